// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encoding, defaults.
package arb_pkg;
    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Client-side bundle of the 8-way arbiter plus FSM/pointer debug taps.
interface rr_arbiter_8_if;
    import arb_pkg::*;

    // Handshake: req[i] is level-sensitive and held until served; a grant is
    // live while grant_valid=1 and ends on done=1 or when req[grant_idx] drops.
    // done is only meaningful while grant_valid=1.
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;
    arb_state_e       state_dbg;
    logic [IDX_W-1:0] ptr_dbg;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout, state_dbg, ptr_dbg
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout, state_dbg, ptr_dbg
    );
endinterface

// File: rtl/rr_arbiter_8_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 7->0.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] enc;

    // rot[0] is the client at ptr, so the lowest set bit is the fairest pick.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    always_comb begin
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = IDX_W'(i);
        end
    end

    assign winner = enc + ptr;
    assign any    = |req;
endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered index/one-hot grant.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    rr_arbiter_8_if.slave  bus
);
    if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
        $error("rr_arbiter_8: HOLD_MAX must be 2..255 and fit in CNT_W bits");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gv_q, gv_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             to_q, to_d;

    logic [IDX_W-1:0] winner;
    logic             any;
    logic             rel_done, rel_drop, rel_to, release_now;

    rr_pick8 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign rel_done    = bus.done;
    assign rel_drop    = ~bus.req[idx_q];
    assign release_now = rel_done | rel_drop | rel_to;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign rel_to = (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == GRANT && !release_now) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign rel_to = 1'b0;
`endif

    // State register together with the registered outputs it drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gv_q    <= 1'b0;
            grant_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gv_q    <= gv_d;
            grant_q <= grant_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any)         state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gv_d    = gv_q;
        grant_d = grant_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d   = winner;
                    gv_d    = 1'b1;
                    grant_d = N_REQ'(1) << winner;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gv_d    = 1'b0;
                    grant_d = '0;
                    ptr_d   = idx_q + 1'b1;
                    // Only a pure hold-limit release is reported as a timeout.
                    to_d    = rel_to & ~rel_done & ~rel_drop;
                end
            end
            default: begin
                gv_d    = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = gv_q;
    assign bus.timeout     = to_q;
    assign bus.state_dbg   = state_q;
    assign bus.ptr_dbg     = ptr_q;
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter that shares one downstream resource, such as a bus slot or display/LED channel, between 8 clients.
- Grant is presented both as a 3-bit index and as an 8-bit one-hot select, so the one-hot can drive an 8-way enable directly.
- Holds the grant until the owner signals completion or drops its request. Fairness comes from a rotating priority pointer.

Parameters:
- HOLD_MAX, 16, maximum cycles a grant may be held before forced release (used only with the optional feature); legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  8  request vector, bit i = client i; level-sensitive, held until served
- done  in  1  current grantee finished; sampled only while grant_valid=1
- grant  out  8  one-hot grant, all zero when no grant
- grant_idx  out  3  binary index of granted client; holds last value when grant_valid=0
- grant_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse on forced release (optional feature)

Behaviour:
- Reset, async assert, sync deassert handled upstream:
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE; priority pointer ptr=0; hold counter=0.
- All outputs are registered; grant is always {8{grant_valid}} & (1<<grant_idx).
- State IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ..., ptr+7 modulo 8 (wrap 7->0).
  - Next edge: grant_idx=winner, grant_valid=1, state=GRANT, counter=0.
  - Latency: req asserted in cycle n -> grant_valid=1 in cycle n+1.
  - If req == 0, stay IDLE with outputs unchanged.
- State GRANT: release condition is done=1, OR req[grant_idx]=0, OR (feature on) counter==HOLD_MAX-1.
  - On release, next edge: grant_valid=0, grant=0, ptr=grant_idx+1 mod 8, state=IDLE.
  - Otherwise counter increments, saturating at its maximum.
- Gap: at least one cycle with grant_valid=0 between consecutive grants, including back-to-back grants to different clients.
- Re-request: the just-served client may be regranted only if no other client is requesting, because ptr has moved past it.
- Simultaneous release conditions: done and req drop in the same cycle count as one release; timeout is not flagged if done=1 in the same cycle.
- done while grant_valid=0 is ignored.
- Requests arriving or changing mid-grant do not preempt; they are considered at the next IDLE cycle.
- Reset asserted mid-grant: outputs clear immediately (async); ptr returns to 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Hold counter is active; forced release at HOLD_MAX cycles of grant_valid=1.
  - timeout pulses high for exactly the cycle in which grant_valid first reads 0 after a forced release.
  - ptr advances as for a normal release.
- Undefined:
  - No counter logic; grant is held indefinitely until done or the request drops.
  - timeout tied to 0. Port list is unchanged.

Decomposition:
- Shared package arb_pkg:
  - localparams N_REQ=8, IDX_W=3.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - HOLD_MAX default.
- One sub-module, rr_pick8:
  - Purely combinational: inputs req[7:0] and ptr[2:0]; outputs winner[2:0] and any.
  - Implemented as rotate, then priority encode, then add ptr modulo 8.
- The top level holds the FSM, ptr, counter and output registers.

Test Plan:
- Reset, then req=8'b0000_0100 -> next cycle grant_valid=1, grant_idx=2, grant=8'h04. Pulse done -> next cycle grant=0; ptr=3.
- ptr=3, req=8'hFF held, done pulsed on every grant -> grant order 3,4,5,6,7,0,1,2 with one idle cycle between grants.
- Grant client 5, then drop req[5] without done -> grant_valid falls next edge; requester 6 (if set) wins after the idle cycle.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h01, never done -> grant_valid high exactly 4 cycles, then timeout=1 for 1 cycle. Client 0 is regranted after the gap since no other requester is present.
- ARB_TIMEOUT_EN undefined, same stimulus -> grant held for 100+ cycles; timeout stays 0.
- Assert reset_n=0 mid-grant, asynchronously between clock edges -> grant, grant_valid and grant_idx go to 0 before the next edge. After release, req=8'h81 -> grant_idx=0, since ptr was reset to 0.
